// File: rtl/fan_control_pkg.sv
// Shared encodings for the multi-channel fan controller: channel states, register
// offsets and MODE values.
package fan_control_pkg;

   typedef enum logic [1:0] {
      StOff   = 2'd0,
      StRamp  = 2'd1,
      StRun   = 2'd2,
      StBoost = 2'd3
   } fan_state_e;

   localparam logic [1:0] RegDuty   = 2'd0;
   localparam logic [1:0] RegMode   = 2'd1;
   localparam logic [1:0] RegThresh = 2'd2;
   localparam logic [1:0] RegStatus = 2'd3;

   localparam logic [1:0] ModeOff    = 2'd0;
   localparam logic [1:0] ModeManual = 2'd1;
   localparam logic [1:0] ModeAuto   = 2'd2;

endpackage

// File: rtl/fan_channel.sv
// One fan channel: DUTY/MODE/THRESH registers, OFF/RAMP/RUN/BOOST state machine and
// the ramped effective duty, all advancing only at PWM period boundaries.
module fan_channel
   import fan_control_pkg::*;
#(
   parameter int unsigned PWM_BITS  = 8,
   parameter int unsigned RAMP_STEP = 4,
   parameter logic [31:0] HYST      = 32'd1000
) (
   input  logic                clock,
   input  logic                reset_n,
   input  logic                wr_en,
   input  logic [1:0]          reg_sel,
   input  logic [31:0]         writedata,
   input  logic [31:0]         current,
   input  logic                period_end,
   output logic [31:0]         rdata,
   output logic [PWM_BITS-1:0] duty_eff
);

   localparam logic [PWM_BITS-1:0] DutyMax = '1;

   logic [PWM_BITS-1:0] duty_q, duty_eff_q, duty_eff_d, ramp_duty;
   logic [1:0]          mode_q;
   logic [31:0]         thresh_q, curr_q, low_thresh;
   fan_state_e          state_q, state_d;
   logic                on, auto, over, under;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         duty_q     <= '0;
         mode_q     <= ModeOff;
         thresh_q   <= '0;
         curr_q     <= '0;
         state_q    <= StOff;
         duty_eff_q <= '0;
      end else begin
         curr_q     <= current;
         state_q    <= state_d;
         duty_eff_q <= duty_eff_d;
         if (wr_en) begin
            case (reg_sel)
               RegDuty:   duty_q   <= writedata[PWM_BITS-1:0];
               RegMode:   mode_q   <= writedata[1:0];
               RegThresh: thresh_q <= writedata;
               default:   ;
            endcase
         end
      end
   end

   assign on         = (mode_q == ModeManual) || (mode_q == ModeAuto);
   assign auto       = (mode_q == ModeAuto);
   assign over       = curr_q > thresh_q;
   assign low_thresh = (thresh_q > HYST) ? thresh_q - HYST : '0;
   assign under      = curr_q < low_thresh;

   // One ramp step toward DUTY, clamped so it lands exactly on the target.
   always_comb begin
      ramp_duty = duty_eff_q;
      if (duty_eff_q < duty_q) begin
         ramp_duty = (32'(duty_q - duty_eff_q) <= RAMP_STEP) ? duty_q
                   : duty_eff_q + PWM_BITS'(RAMP_STEP);
      end else if (duty_eff_q > duty_q) begin
         ramp_duty = (32'(duty_eff_q - duty_q) <= RAMP_STEP) ? duty_q
                   : duty_eff_q - PWM_BITS'(RAMP_STEP);
      end
   end

   always_comb begin
      state_d    = state_q;
      duty_eff_d = duty_eff_q;
      if (period_end) begin
         if (!on) begin
            state_d    = StOff;
            duty_eff_d = '0;
         end else begin
            unique case (state_q)
               StOff: begin
                  state_d    = StRamp;
                  duty_eff_d = ramp_duty;
               end
               StRamp, StRun: begin
                  if (auto && over) begin
                     state_d    = StBoost;
                     duty_eff_d = DutyMax;
                  end else begin
                     duty_eff_d = ramp_duty;
                     state_d    = (ramp_duty == duty_q) ? StRun : StRamp;
                  end
               end
               StBoost: begin
                  if (!auto || under) state_d = StRamp;
               end
               default: ;
            endcase
         end
      end
   end

   always_comb begin
      rdata = '0;
      unique case (reg_sel)
         RegDuty:   rdata[PWM_BITS-1:0] = duty_q;
         RegMode:   rdata[1:0] = mode_q;
         RegThresh: rdata = thresh_q;
         RegStatus: begin
            rdata[1:0]             = state_q;
            rdata[PWM_BITS+15:16]  = duty_eff_q;
         end
         default: ;
      endcase
   end

   assign duty_eff = duty_eff_q;

endmodule

// File: rtl/fan_control_multi.sv
// Multi-channel PWM fan controller: shared prescaler and PWM counter, Avalon-MM
// register decode, and one fan_channel per channel.
module fan_control_multi
   import fan_control_pkg::*;
#(
   parameter int unsigned NUM_CH    = 4,
   parameter int unsigned PWM_BITS  = 8,
   parameter int unsigned PRESCALE  = 195,
   parameter int unsigned RAMP_STEP = 4,
   parameter logic [31:0] HYST      = 32'd1000
) (
   input  logic                  clock,
   input  logic                  reset_n,
   input  logic [4:0]            address,
   input  logic                  write,
   input  logic                  read,
   input  logic [31:0]           writedata,
   output logic [31:0]           readdata,
   input  logic [32*NUM_CH-1:0]  current_average,
   output logic [NUM_CH-1:0]     pwm
);

   logic [15:0]         presc_q;
   logic [PWM_BITS-1:0] pwm_cnt_q;
   logic                tick, period_end;
   logic [2:0]          ch_sel;
   logic [1:0]          reg_sel;
   logic [31:0]         rd_mux;
   logic [31:0]         ch_rdata [NUM_CH];
   logic [PWM_BITS-1:0] duty_eff [NUM_CH];

   assign tick       = (presc_q == 16'(PRESCALE - 1));
   assign period_end = tick && (pwm_cnt_q == '1);
   assign ch_sel     = address[4:2];
   assign reg_sel    = address[1:0];

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         presc_q   <= '0;
         pwm_cnt_q <= '0;
      end else if (tick) begin
         presc_q   <= '0;
         pwm_cnt_q <= pwm_cnt_q + 1'b1;
      end else begin
         presc_q   <= presc_q + 16'd1;
      end
   end

   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      fan_channel #(
         .PWM_BITS  (PWM_BITS),
         .RAMP_STEP (RAMP_STEP),
         .HYST      (HYST)
      ) u_ch (
         .clock      (clock),
         .reset_n    (reset_n),
         .wr_en      (write && (ch_sel == 3'(g)) && (reg_sel != RegStatus)),
         .reg_sel    (reg_sel),
         .writedata  (writedata),
         .current    (current_average[32*g +: 32]),
         .period_end (period_end),
         .rdata      (ch_rdata[g]),
         .duty_eff   (duty_eff[g])
      );

      always_ff @(posedge clock or negedge reset_n) begin
         if (!reset_n) pwm[g] <= 1'b0;
         else          pwm[g] <= pwm_cnt_q < duty_eff[g];
      end
   end

   // Channels that do not exist never match, so their reads fall through to 0.
   always_comb begin
      rd_mux = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (ch_sel == 3'(i)) rd_mux = ch_rdata[i];
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n)            readdata <= '0;
      else if (read && !write) readdata <= rd_mux;
   end

endmodule

// File: tb/tb_fan_control_multi.sv
// Directed bench for fan_control_multi with PRESCALE=1 (one PWM count per clock);
// register reads go through an expected-value queue checked when readdata is valid.
module tb_fan_control_multi;
   import fan_control_pkg::*;

   localparam int unsigned NCH = 4;

   logic             clock = 1'b0;
   logic             reset_n = 1'b0;
   logic [4:0]       address = '0;
   logic             write = 1'b0;
   logic             read = 1'b0;
   logic [31:0]      writedata = '0;
   logic [31:0]      readdata;
   logic [32*NCH-1:0] current_average = '0;
   logic [NCH-1:0]   pwm;

   int          n_checks = 0;
   int          n_pass = 0;
   logic [7:0]  mcnt;
   logic [31:0] exp_q [$];
   string       tag_q [$];

   fan_control_multi #(
      .NUM_CH    (NCH),
      .PWM_BITS  (8),
      .PRESCALE  (1),
      .RAMP_STEP (4),
      .HYST      (32'd1000)
   ) dut (
      .clock           (clock),
      .reset_n         (reset_n),
      .address         (address),
      .write           (write),
      .read            (read),
      .writedata       (writedata),
      .readdata        (readdata),
      .current_average (current_average),
      .pwm             (pwm)
   );

   always #5 clock = ~clock;

   // Reference PWM count: with PRESCALE=1 it advances once per clock from reset release.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) mcnt <= '0;
      else          mcnt <= mcnt + 8'd1;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic wr(input logic [2:0] ch, input logic [1:0] rg, input logic [31:0] data);
      address   = {ch, rg};
      writedata = data;
      write     = 1'b1;
      tick();
      write     = 1'b0;
   endtask

   task automatic rd(input logic [2:0] ch, input logic [1:0] rg, input logic [31:0] exp,
                     input string tag);
      logic [31:0] e;
      string       t;
      address = {ch, rg};
      read    = 1'b1;
      exp_q.push_back(exp);
      tag_q.push_back(tag);
      tick();
      read = 1'b0;
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      check(t, readdata, e);
   endtask

   task automatic wait_at(input logic [7:0] k);
      tick();
      for (int n = 0; n < 260 && mcnt != k; n++) tick();
   endtask

   // Each call crosses exactly one period boundary when started past mid-period.
   task automatic periods(input int n);
      repeat (n) wait_at(8'd128);
   endtask

   task automatic count_high(input int ch, output int c);
      c = 0;
      repeat (256) begin
         tick();
         if (pwm[ch]) c++;
      end
   endtask

   function automatic logic [31:0] st(input int duty, input int state);
      return (32'(duty) << 16) | 32'(state);
   endfunction

   initial begin
      int          c;
      int          errs;
      logic [7:0]  prev;

      repeat (3) tick();
      check("rst_pwm", 32'(pwm), 32'd0);
      check("rst_readdata", readdata, 32'd0);
      reset_n = 1'b1;
      rd(3'd0, RegDuty, 32'd0, "rst_duty");
      rd(3'd0, RegMode, 32'd0, "rst_mode");
      rd(3'd0, RegThresh, 32'd0, "rst_thresh");
      rd(3'd0, RegStatus, 32'd0, "rst_status");

      // Manual ramp 0 -> 128 on channel 0
      wait_at(8'd128);
      wr(3'd0, RegDuty, 32'd128);
      wr(3'd0, RegMode, 32'(ModeManual));
      periods(31);
      rd(3'd0, RegStatus, st(124, 1), "s1_ramp31");
      periods(1);
      rd(3'd0, RegStatus, st(128, 2), "s1_run");
      count_high(0, c);
      check("s1_pwm_high", 32'(c), 32'd128);

      // DUTY change mid-period must not disturb the current period
      wait_at(8'd16);
      wr(3'd0, RegDuty, 32'd64);
      errs = 0;
      for (int n = 0; n < 260 && mcnt != 8'd1; n++) begin
         tick();
         prev = mcnt - 8'd1;
         if (pwm[0] !== (prev < 8'd128)) errs++;
      end
      check("s2_wave_hold", 32'(errs), 32'd0);
      wait_at(8'd128);
      rd(3'd0, RegStatus, st(124, 1), "s2_first_step");

      // AUTO with boost and hysteresis on channel 1
      wait_at(8'd128);
      wr(3'd1, RegThresh, 32'd5000);
      wr(3'd1, RegDuty, 32'd64);
      wr(3'd1, RegMode, 32'(ModeAuto));
      periods(16);
      rd(3'd1, RegStatus, st(64, 2), "s3_run64");
      current_average[63:32] = 32'd5000;
      periods(1);
      rd(3'd1, RegStatus, st(64, 2), "s3_equal_no_boost");
      current_average[63:32] = 32'd6000;
      periods(1);
      rd(3'd1, RegStatus, st(255, 3), "s3_boost");
      count_high(1, c);
      check("s3_pwm_boost", 32'(c), 32'd255);
      current_average[63:32] = 32'd4500;
      periods(1);
      rd(3'd1, RegStatus, st(255, 3), "s3_hold_4500");
      current_average[63:32] = 32'd4000;
      periods(1);
      rd(3'd1, RegStatus, st(255, 3), "s3_hold_4000");
      current_average[63:32] = 32'd3999;
      periods(1);
      rd(3'd1, RegStatus, st(255, 1), "s3_exit");
      periods(47);
      rd(3'd1, RegStatus, st(67, 1), "s3_ramp_down");
      periods(1);
      rd(3'd1, RegStatus, st(64, 2), "s3_settled");

      // Ignored writes and zero reads
      rd(3'd1, RegThresh, 32'd5000, "s4_thresh");
      rd(3'd5, RegDuty, 32'd0, "s4_rd_ch5");
      wr(3'd5, RegDuty, 32'hAB);
      wr(3'd3, RegStatus, 32'hFFFF_FFFF);
      rd(3'd1, RegDuty, 32'd64, "s4_no_alias");
      rd(3'd5, RegDuty, 32'd0, "s4_ch5_after");
      rd(3'd7, RegThresh, 32'd0, "s4_ch7");
      rd(3'd3, RegStatus, 32'd0, "s4_status_ro");
      rd(3'd3, RegDuty, 32'd0, "s4_ch3_duty");
      rd(3'd3, RegMode, 32'd0, "s4_ch3_mode");
      rd(3'd1, RegThresh, 32'd5000, "s4_thresh_again");
      repeat (3) tick();
      check("s4_hold", readdata, 32'd5000);

      // Clamped ramps on channel 2
      wait_at(8'd128);
      wr(3'd2, RegDuty, 32'd2);
      wr(3'd2, RegMode, 32'(ModeManual));
      periods(1);
      rd(3'd2, RegStatus, st(2, 1), "s5_clamp_up");
      periods(1);
      rd(3'd2, RegStatus, st(2, 2), "s5_run2");
      wr(3'd2, RegDuty, 32'd255);
      periods(63);
      rd(3'd2, RegStatus, st(254, 1), "s5_up63");
      periods(1);
      rd(3'd2, RegStatus, st(255, 2), "s5_top");
      wr(3'd2, RegDuty, 32'd0);
      periods(63);
      rd(3'd2, RegStatus, st(3, 1), "s5_down63");
      periods(1);
      rd(3'd2, RegStatus, st(0, 2), "s5_bottom");

      // Reset during a ramp on channel 3
      wait_at(8'd128);
      wr(3'd3, RegDuty, 32'd200);
      wr(3'd3, RegMode, 32'(ModeManual));
      periods(10);
      wait_at(8'd5);
      check("s6_pwm_high", 32'(pwm[3]), 32'd1);
      reset_n = 1'b0;
      #1;
      check("s6_async_low", 32'(pwm), 32'd0);
      repeat (2) tick();
      reset_n = 1'b1;
      check("s6_readdata", readdata, 32'd0);
      for (int ch = 0; ch < NCH; ch++) rd(3'(ch), RegStatus, 32'd0, "s6_status");
      rd(3'd1, RegThresh, 32'd0, "s6_thresh");
      count_high(3, c);
      check("s6_pwm_off", 32'(c), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
